seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider for the 4-bit ALU. It is the inverse-direction companion of the ripple-carry adder.
- Each iteration is one shift-and-subtract step. The subtract is built on the existing full_adder cell, using an inverted divisor and carry-in of 1.
- Sits beside the adder in the ALU execute path.
- Uses a start/ready/done handshake, so the ALU controller can issue one divide and wait for the result.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/full_adder.sv | 13 +
 rtl/subtractor.sv | 28 ++
 rtl/seq_divider.sv | 122 ++++++++++++
 tb/tb_seq_divider.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the 4-bit ALU datapath and its sequential divider.
package alu_pkg;

    localparam int ALU_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_DIV = 3'd5
    } alu_op_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell shared by the ALU adder and subtractor chains.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/subtractor.sv
// Ripple subtractor a - b built from full_adder cells: a + ~b + 1.
module subtractor #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (~b[i]),
            .c_in (carry[i]),
            .sum  (diff[i]),
            .c_out(carry[i+1])
        );
    end

    // No carry out of a + ~b + 1 means b was larger than a.
    assign borrow = ~carry[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with start/ready/done handshake.
//
// state | meaning
// IDLE  | ready for a new operation, results held
// RUN   | one shift-and-subtract step per cycle
// DONE  | one-cycle done pulse, results valid
module seq_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    div_state_t       state;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] quo_acc;
    logic [WIDTH-1:0] den;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic             trial_borrow;
    logic             restore;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic             last_step;

    // rem_acc stays below the divisor and, before the final step, below
    // 2^(WIDTH-1), so its top bit is always zero and this equals {1'b0, R_shifted}.
    assign r_shift = {rem_acc, quo_acc[WIDTH-1]};

    subtractor #(
        .WIDTH(WIDTH + 1)
    ) u_sub (
        .a     (r_shift),
        .b     ({1'b0, den}),
        .diff  (trial),
        .borrow(trial_borrow)
    );

    // Both the trial sign bit and the borrow flag mark a negative trial.
    assign restore   = trial[WIDTH] | trial_borrow;
    assign r_next    = restore ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_next    = {quo_acc[WIDTH-2:0], ~restore};
    assign last_step = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ready       <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            rem_acc     <= '0;
            quo_acc     <= '0;
            den         <= '0;
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ready <= 1'b0;
                        if (divisor != '0) begin
                            quo_acc <= dividend;
                            den     <= divisor;
                            rem_acc <= '0;
                            count   <= '0;
                            busy    <= 1'b1;
                            state   <= RUN;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                RUN: begin
                    rem_acc <= r_next;
                    quo_acc <= q_next;
                    count   <= count + 1'b1;
                    if (last_step) begin
                        quotient    <= q_next;
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and sweep checks for seq_divider at WIDTH=4.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int failures = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called on a negedge in IDLE; returns on the negedge where done is seen (or budget runs out).
    task automatic run_div(input int a, input int b, output int lat, output int busy_n,
                           output int held);
        logic [W-1:0] q0, r0;
        logic         z0;
        q0 = quotient;
        r0 = remainder;
        z0 = div_by_zero;
        held = 1;
        start = 1'b1;
        dividend = W'(a);
        divisor = W'(b);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dividend = ~W'(a);
        divisor = ~W'(b);
        lat = 1;
        busy_n = 0;
        while (!done && lat < 20) begin
            if (busy) busy_n++;
            if (quotient !== q0 || remainder !== r0 || div_by_zero !== z0) held = 0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic leave_done(input string tag);
        chk({tag, "_done"}, done, 1);
        @(negedge clk);
        chk({tag, "_done_drop"}, done, 0);
        chk({tag, "_ready_back"}, ready, 1);
    endtask

    int lat, busy_n, held, n, saw_done;
    int bnd_a[4] = '{15, 2, 0, 15};
    int bnd_b[4] = '{1, 7, 5, 15};
    int bnd_q[4] = '{15, 0, 0, 1};
    int bnd_r[4] = '{0, 2, 0, 0};

    initial begin
        // reset
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", ready, 1);

        // basic 13/3
        run_div(13, 3, lat, busy_n, held);
        chk("b13_lat", lat, 5);
        chk("b13_busy_cycles", busy_n, 4);
        chk("b13_held", held, 1);
        chk("b13_q", quotient, 4);
        chk("b13_r", remainder, 1);
        chk("b13_dbz", div_by_zero, 0);
        leave_done("b13");

        // boundary operands
        for (int i = 0; i < 4; i++) begin
            run_div(bnd_a[i], bnd_b[i], lat, busy_n, held);
            chk($sformatf("bnd%0d_lat", i), lat, 5);
            chk($sformatf("bnd%0d_q", i), quotient, bnd_q[i]);
            chk($sformatf("bnd%0d_r", i), remainder, bnd_r[i]);
            leave_done($sformatf("bnd%0d", i));
        end

        // divide by zero 9/0
        run_div(9, 0, lat, busy_n, held);
        chk("dz_lat", lat, 1);
        chk("dz_busy_cycles", busy_n, 0);
        chk("dz_q", quotient, 15);
        chk("dz_r", remainder, 9);
        chk("dz_dbz", div_by_zero, 1);
        leave_done("dz");

        // start pulsed during RUN is ignored
        start = 1'b1;
        dividend = 4'd13;
        divisor = 4'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        dividend = 4'd6;
        divisor = 4'd2;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ign_q", quotient, 4);
        chk("ign_r", remainder, 1);
        chk("ign_dbz", div_by_zero, 0);
        leave_done("ign");
        run_div(6, 2, lat, busy_n, held);
        chk("ign2_q", quotient, 3);
        chk("ign2_r", remainder, 0);
        leave_done("ign2");

        // reset in the middle of RUN
        start = 1'b1;
        dividend = 4'd14;
        divisor = 4'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_ready", ready, 1);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_q", quotient, 0);
        chk("mid_r", remainder, 0);
        chk("mid_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        chk("mid_no_done", saw_done, 0);
        chk("mid_q_still", quotient, 0);
        run_div(14, 4, lat, busy_n, held);
        chk("mid2_q", quotient, 3);
        chk("mid2_r", remainder, 2);
        leave_done("mid2");

        // exhaustive sweep, start held high
        start = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                n = 0;
                while (!ready && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                dividend = W'(a);
                divisor = W'(b);
                @(posedge clk);
                @(negedge clk);
                lat = 1;
                while (!done && lat < 20) begin
                    @(negedge clk);
                    lat++;
                end
                if (b == 0) begin
                    chk($sformatf("sw_%0d_%0d_lat", a, b), lat, 1);
                    chk($sformatf("sw_%0d_%0d_q", a, b), quotient, 15);
                    chk($sformatf("sw_%0d_%0d_r", a, b), remainder, a);
                    chk($sformatf("sw_%0d_%0d_dbz", a, b), div_by_zero, 1);
                end else begin
                    chk($sformatf("sw_%0d_%0d_lat", a, b), lat, 5);
                    chk($sformatf("sw_%0d_%0d_q", a, b), quotient, a / b);
                    chk($sformatf("sw_%0d_%0d_r", a, b), remainder, a % b);
                    chk($sformatf("sw_%0d_%0d_dbz", a, b), div_by_zero, 0);
                end
            end
        end
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
